// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: single-outstanding req/ack data-bus access,
// pipeline stall while in flight, and the registered MEM/WB write-back triple.
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_memop,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_sdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        stall_req,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        addr_err
);

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic {IDLE, BUS} state_t;

    state_t state;

    logic is_load;
    logic is_store;
    logic is_byte;
    logic is_half;
    logic is_word;
    logic misalign;
    logic mem_access;

    function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] a);
        logic [3:0] s;
        case (op)
            OP_LB, OP_LBU, OP_SB: s = 4'b0001 << a;
            OP_LH, OP_LHU, OP_SH: s = a[1] ? 4'b1100 : 4'b0011;
            OP_LW, OP_SW:         s = 4'b1111;
            default:              s = 4'b0000;
        endcase
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] lane_wdata(input logic [3:0] op,
                                                     input logic [DATA_W-1:0] sdata);
        logic [DATA_W-1:0] w;
        case (op)
            OP_SB:   w = {4{sdata[7:0]}};
            OP_SH:   w = {2{sdata[15:0]}};
            default: w = sdata;
        endcase
        return w;
    endfunction

    // Picks the addressed lane(s) and sign- or zero-extends to a full register.
    function automatic logic [DATA_W-1:0] load_extend(input logic [3:0] op,
                                                      input logic [1:0] a,
                                                      input logic [DATA_W-1:0] rdata);
        logic        [7:0]        b;
        logic        [15:0]       h;
        logic signed [7:0]        bs;
        logic signed [15:0]       hs;
        logic signed [DATA_W-1:0] r;
        case (a)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h  = a[1] ? rdata[31:16] : rdata[15:0];
        bs = signed'(b);
        hs = signed'(h);
        case (op)
            OP_LB:   r = DATA_W'(bs);
            OP_LBU:  r = signed'({24'd0, b});
            OP_LH:   r = DATA_W'(hs);
            OP_LHU:  r = signed'({16'd0, h});
            default: r = signed'(rdata);
        endcase
        return unsigned'(r);
    endfunction

    always_comb begin
        is_load  = (mem_memop >= OP_LB) && (mem_memop <= OP_LW);
        is_store = (mem_memop >= OP_SB) && (mem_memop <= OP_SW);
        is_byte  = (mem_memop == OP_LB) || (mem_memop == OP_LBU) || (mem_memop == OP_SB);
        is_half  = (mem_memop == OP_LH) || (mem_memop == OP_LHU) || (mem_memop == OP_SH);
        is_word  = (mem_memop == OP_LW) || (mem_memop == OP_SW);
        mem_access = is_load || is_store;
        misalign = (is_half && mem_addr[0]) || (is_word && (mem_addr[1:0] != 2'b00));
    end

    // Stall drops in the ack cycle so the next instruction advances at that edge.
    always_comb begin
        stall_req = 1'b0;
        if (state == IDLE)
            stall_req = mem_access && !misalign;
        else
            stall_req = !bus_ack;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_sel   <= '0;
            bus_wdata <= '0;
            wb_wd     <= '0;
            wb_wreg   <= 1'b0;
            wb_wdata  <= '0;
            addr_err  <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!mem_access) begin
                        wb_wd    <= mem_wd;
                        wb_wreg  <= mem_wreg;
                        wb_wdata <= mem_wdata;
                    end else if (misalign) begin
                        addr_err <= 1'b1;
                        wb_wd    <= '0;
                        wb_wreg  <= 1'b0;
                        wb_wdata <= '0;
                    end else begin
                        state     <= BUS;
                        bus_req   <= 1'b1;
                        bus_we    <= is_store;
                        bus_addr  <= {mem_addr[31:2], 2'b00};
                        bus_sel   <= lane_sel(mem_memop, mem_addr[1:0]);
                        bus_wdata <= lane_wdata(mem_memop, mem_sdata);
                    end
                end
                BUS: begin
                    if (bus_ack) begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        if (is_load) begin
                            wb_wd    <= mem_wd;
                            wb_wreg  <= mem_wreg;
                            wb_wdata <= load_extend(mem_memop, mem_addr[1:0], bus_rdata);
                        end else begin
                            wb_wd    <= '0;
                            wb_wreg  <= 1'b0;
                            wb_wdata <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{is_byte, ADDR_W[0]};

endmodule
